// File: rtl/rc4_key_loader.sv
// RC4 key loader: buffers a variable-length key byte stream and serves it
// to the KSA through a wrapping read pointer. Optional macro RC4_KEY_ZEROIZE_EN.
module rc4_key_loader #(
    parameter int unsigned KEY_MAX_BYTES = 16,
    parameter int unsigned KEY_MIN_BYTES = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_wr_vld,
    input  logic [7:0] key_wr_data,
    input  logic       key_wr_last,
    output logic       key_wr_rdy,
    input  logic       key_clr,
    input  logic       ksa_start,
    input  logic       ksa_adv,
    output logic [7:0] key_byte,
    output logic       key_vld,
    output logic [4:0] key_len,
    output logic       key_err
);

    localparam int unsigned PTR_W   = (KEY_MAX_BYTES > 1) ? $clog2(KEY_MAX_BYTES) : 1;
    localparam logic [4:0]  MAX_LEN = 5'(KEY_MAX_BYTES);
    localparam logic [4:0]  MIN_LEN = 5'(KEY_MIN_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READY,
        ERR
`ifdef RC4_KEY_ZEROIZE_EN
        , ZERO
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         key_len_q, key_len_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [7:0]         key_buf_q [KEY_MAX_BYTES];
    logic [7:0]         key_buf_d [KEY_MAX_BYTES];
    logic               xfer;
    logic [4:0]         len_inc;
`ifdef RC4_KEY_ZEROIZE_EN
    logic [PTR_W-1:0]   zcnt_q, zcnt_d;
`endif

    assign xfer    = key_wr_vld && key_wr_rdy;
    assign len_inc = key_len_q + 5'd1;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
`ifdef RC4_KEY_ZEROIZE_EN
        if (key_clr) begin
            state_d = ZERO;
        end else begin
`else
        if (key_clr) begin
            state_d = IDLE;
        end else begin
`endif
            case (state_q)
                IDLE, LOAD: begin
                    if (xfer) begin
                        if (key_wr_last) begin
                            state_d = (len_inc >= MIN_LEN && len_inc <= MAX_LEN) ? READY : ERR;
                        end else if (key_len_q == MAX_LEN - 5'd1) begin
                            state_d = ERR;
                        end else begin
                            state_d = LOAD;
                        end
                    end
                end
`ifdef RC4_KEY_ZEROIZE_EN
                ZERO: begin
                    if (zcnt_q == PTR_W'(KEY_MAX_BYTES - 1)) begin
                        state_d = IDLE;
                    end
                end
`endif
                default: state_d = state_q;
            endcase
        end
    end

    // Outputs
    always_comb begin
        key_wr_rdy = (state_q == IDLE) || (state_q == LOAD);
        key_vld    = (state_q == READY);
        key_err    = (state_q == ERR);
        key_len    = key_len_q;
        key_byte   = key_vld ? key_buf_q[ptr_q] : 8'h00;
    end

    // Datapath: length, read pointer, buffer writes
    always_comb begin
        key_len_d = key_len_q;
        ptr_d     = ptr_q;
        key_buf_d = key_buf_q;
`ifdef RC4_KEY_ZEROIZE_EN
        zcnt_d    = zcnt_q;
`endif
        if (key_clr) begin
            key_len_d = '0;
            ptr_d     = '0;
`ifdef RC4_KEY_ZEROIZE_EN
            zcnt_d    = '0;
`endif
        end else begin
            if (xfer) begin
                key_buf_d[key_len_q[PTR_W-1:0]] = key_wr_data;
                key_len_d                       = len_inc;
            end
            if (state_q == READY) begin
                if (ksa_start) begin
                    ptr_d = '0;
                end else if (ksa_adv) begin
                    ptr_d = (5'(ptr_q) == key_len_q - 5'd1) ? '0 : ptr_q + 1'b1;
                end
            end
`ifdef RC4_KEY_ZEROIZE_EN
            if (state_q == ZERO) begin
                key_buf_d[zcnt_q] = 8'h00;
                zcnt_d            = zcnt_q + 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_len_q <= '0;
            ptr_q     <= '0;
`ifdef RC4_KEY_ZEROIZE_EN
            zcnt_q    <= '0;
`endif
        end else begin
            key_len_q <= key_len_d;
            ptr_q     <= ptr_d;
`ifdef RC4_KEY_ZEROIZE_EN
            zcnt_q    <= zcnt_d;
`endif
        end
    end

    // Key storage is deliberately not reset
    always_ff @(posedge clk) begin
        key_buf_q <= key_buf_d;
    end

endmodule
